// File: rtl/ram_arb_pkg.sv
// Shared types and sizes for the four-port RAM front end.
// The tag struct travels down the read pipeline alongside each read command.
package ram_arb_pkg;
  localparam int NUM_PORTS  = 4;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 8;
  localparam int RAM_RD_LAT = 1;

  typedef logic [1:0] port_id_t;

  typedef struct packed {
    logic     valid;
    port_id_t port_id;
  } tag_t;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input port_id_t id);
    logic [NUM_PORTS-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/ram_1.sv
// Single-port 1024x8 synchronous RAM: write on cs&wr, registered read on cs&!wr.
// data_out is valid one cycle after the read command is sampled.
module ram_1
  import ram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              cs,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] mem [1<<ADDR_W];

  always_ff @(posedge clk) begin
    if (cs) begin
      if (wr) mem[addr] <= data_in;
      else    data_out  <= mem[addr];
    end
  end

endmodule

// File: rtl/rr_arb4.sv
// Combinational round-robin picker for four requesters.
// Searches upward from ptr, wrapping 3->0; the first set request bit wins.
module rr_arb4
  import ram_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] winner
);

  logic     found;
  port_id_t idx;

  always_comb begin
    gnt    = '0;
    winner = ptr;
    found  = 1'b0;
    idx    = '0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      // 2-bit addition gives the 3->0 wrap for free
      idx = ptr + port_id_t'(off);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    if (found) gnt = port_onehot(winner);
  end

endmodule

// File: rtl/ram_quad_port_arbiter.sv
// Four requester ports share one RAM port via round-robin arbitration.
// Handshake: a port raises p_req with its command held stable; the command is
// taken at the posedge where p_gnt is high for that port, and p_req may then
// carry the next command. Reads return later as a one-hot rd_valid pulse.
module ram_quad_port_arbiter
  import ram_arb_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        p_req,
  input  logic [NUM_PORTS-1:0]        p_wr,
  input  logic [NUM_PORTS*ADDR_W-1:0] p_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] p_wdata,
  output logic [NUM_PORTS-1:0]        p_gnt,
  output logic [NUM_PORTS-1:0]        rd_valid,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        ram_cs,
  output logic                        ram_wr,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_data_in,
  input  logic [DATA_W-1:0]           ram_data_out
);

  port_id_t                ptr;
  port_id_t                winner;
  logic [NUM_PORTS-1:0]    arb_gnt;
  logic                    accept;
  tag_t                    new_tag;
  tag_t                    out_tag;
  tag_t [RAM_RD_LAT:0]     tags;

  rr_arb4 u_arb (
    .req    (p_req),
    .ptr    (ptr),
    .gnt    (arb_gnt),
    .winner (winner)
  );

  // Grant is forced low while reset is asserted so nothing looks accepted.
  assign p_gnt  = rst_n ? arb_gnt : '0;
  assign accept = |p_gnt;

  always_comb begin
    new_tag         = '0;
    new_tag.valid   = accept && !p_wr[winner];
    new_tag.port_id = winner;
  end

  assign out_tag = tags[RAM_RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= winner + port_id_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_cs      <= 1'b0;
      ram_wr      <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
    end else if (accept) begin
      ram_cs      <= 1'b1;
      ram_wr      <= p_wr[winner];
      ram_addr    <= p_addr[winner*ADDR_W +: ADDR_W];
      ram_data_in <= p_wdata[winner*DATA_W +: DATA_W];
    end else begin
      ram_cs <= 1'b0;
      ram_wr <= 1'b0;
    end
  end

  // Stage 0 is loaded at acceptance; the last stage lines up with data_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tags <= '0;
    end else begin
      tags <= {tags[RAM_RD_LAT-1:0], new_tag};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= '0;
      rd_data  <= '0;
    end else if (out_tag.valid) begin
      rd_valid <= port_onehot(out_tag.port_id);
      rd_data  <= ram_data_out;
    end else begin
      rd_valid <= '0;
    end
  end

endmodule
